mux4x1_rr_sched: RTL and testbench



---
 rtl/mux4x1_rr_sched_pkg.sv | 22 ++
 rtl/mux4x1_rr_sched_if.sv | 28 ++
 rtl/mux4x1_rr_sched_rr_pick4.sv | 27 ++
 rtl/mux4x1_rr_sched.sv | 140 ++++++++++++++
 tb/tb_mux4x1_rr_sched.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/mux4x1_rr_sched_pkg.sv
// Shared definitions for the 4-lane round-robin byte scheduler.
// The optional strict-priority mode for lane 0 is selected with MUX_LANE0_PRIO_EN.
package pcie_mux_pkg;

   localparam int NUM_LANES     = 4;
   localparam int LANE_W        = 2;
   localparam int MAX_BURST_DEF = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Convert a lane index into a one-hot grant vector.
   function automatic logic [NUM_LANES-1:0] onehot(input logic [LANE_W-1:0] idx);
      logic [NUM_LANES-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/mux4x1_rr_sched_if.sv
// Lane-side bus of the round-robin scheduler: four data lanes with requests in,
// grant / registered byte / status out.
interface mux4x1_rr_sched_if #(
   parameter int DATA_W = 8
) ();
   logic [DATA_W-1:0] in0;
   logic [DATA_W-1:0] in1;
   logic [DATA_W-1:0] in2;
   logic [DATA_W-1:0] in3;
   logic [3:0]        req;
   logic [3:0]        gnt;
   logic [DATA_W-1:0] out;
   logic              valid_out;
   logic [1:0]        lane_id;
   logic              busy;

   // Requesters / downstream side.
   modport master (
      output in0, in1, in2, in3, req,
      input  gnt, out, valid_out, lane_id, busy
   );

   // Scheduler side.
   modport slave (
      input  in0, in1, in2, in3, req,
      output gnt, out, valid_out, lane_id, busy
   );
endinterface

// File: rtl/mux4x1_rr_sched_rr_pick4.sv
// Combinational round-robin picker: first requesting lane searching
// ptr+1, ptr+2, ptr+3, ptr (mod 4).
module rr_pick4
   import pcie_mux_pkg::*;
(
   input  logic [NUM_LANES-1:0] req,
   input  logic [LANE_W-1:0]    ptr,
   output logic [LANE_W-1:0]    pick,
   output logic                 any
);

   // Walk the search order backwards so the nearest lane after ptr is written last and wins.
   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
      pick = '0;
      any  = 1'b0;
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
         logic [LANE_W-1:0] idx;
         idx = ptr + LANE_W'(i) + LANE_W'(1);
         if (req[idx]) begin
            pick = idx;
            any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux4x1_rr_sched.sv
// Round-robin scheduler sharing one registered byte output between four lanes,
// with bursts bounded by MAX_BURST and forced rotation afterwards.
// Define MUX_LANE0_PRIO_EN to give lane 0 strict priority at every grant decision.
module mux4x1_rr_sched
   import pcie_mux_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = MAX_BURST_DEF
) (
   input  logic              clk4f,
   input  logic              reset,
   mux4x1_rr_sched_if.slave  bus
);

   state_t                state_q, state_d;
   logic [LANE_W-1:0]     ptr_q, ptr_d;
   logic [LANE_W-1:0]     g_q, g_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [NUM_LANES-1:0]  gnt_q, gnt_d;
   logic [NUM_LANES-1:0]  req;
   logic [LANE_W-1:0]     new_ptr, pick_ptr, pick, dec_lane;
   logic                  any, xfer, burst_done, rotate;
   logic [DATA_W-1:0]     lane_data;
   logic [DATA_W-1:0]     out_q;
   logic                  valid_q;
   logic [LANE_W-1:0]     lane_id_q;

   assign req        = bus.req;
   assign xfer       = (state_q == GRANT) && req[g_q];
   assign burst_done = ({1'b0, cnt_q} + 5'd1) == 5'(MAX_BURST);
   // A granted lane that has dropped req cannot transfer, so it rotates immediately.
   assign rotate     = !req[g_q] || burst_done;

`ifdef MUX_LANE0_PRIO_EN
   // Lane 0 bursts leave the pointer alone so lanes 1-3 keep their rotation order.
   assign new_ptr  = (g_q == '0) ? ptr_q : g_q;
   assign dec_lane = req[0] ? '0 : pick;
`else
   assign new_ptr  = g_q;
   assign dec_lane = pick;
`endif

   // Rotation decisions search from the pointer the rotation is about to commit.
   assign pick_ptr = (state_q == GRANT) ? new_ptr : ptr_q;

   rr_pick4 u_pick (
      .req  (req),
      .ptr  (pick_ptr),
      .pick (pick),
      .any  (any)
   );

   // Granted lane data source.
   always_comb begin
      case (g_q)
         2'd0:    lane_data = bus.in0;
         2'd1:    lane_data = bus.in1;
         2'd2:    lane_data = bus.in2;
         default: lane_data = bus.in3;
      endcase
   end

   // Next state, grant, pointer and burst count.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      g_d     = g_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      case (state_q)
         IDLE: begin
            if (any) begin
               state_d = GRANT;
               g_d     = dec_lane;
               gnt_d   = onehot(dec_lane);
               cnt_d   = '0;
            end
         end
         GRANT: begin
            if (rotate) begin
               ptr_d = new_ptr;
               cnt_d = '0;
               if (any) begin
                  g_d   = dec_lane;
                  gnt_d = onehot(dec_lane);
               end else begin
                  state_d = IDLE;
                  gnt_d   = '0;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   // Control state registers with synchronous reset; lane 0 wins first (ptr=3).
   always_ff @(posedge clk4f) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= 2'd3;
         g_q     <= '0;
         cnt_q   <= '0;
         gnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         g_q     <= g_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
      end
   end

   // Output byte register: captures a transfer, otherwise holds byte and lane.
   always_ff @(posedge clk4f) begin
      if (reset) begin
         out_q     <= '0;
         valid_q   <= 1'b0;
         lane_id_q <= '0;
      end else if (xfer) begin
         out_q     <= lane_data;
         valid_q   <= 1'b1;
         lane_id_q <= g_q;
      end else begin
         valid_q   <= 1'b0;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.out       = out_q;
   assign bus.valid_out = valid_q;
   assign bus.lane_id   = lane_id_q;
   assign bus.busy      = (state_q == GRANT);

endmodule

// File: tb/tb_mux4x1_rr_sched.sv
// Directed testbench for mux4x1_rr_sched with hand-computed expectations.
module tb_mux4x1_rr_sched;

   logic clk;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   mux4x1_rr_sched_if #(.DATA_W(8)) bus ();

   mux4x1_rr_sched #(.DATA_W(8), .MAX_BURST(4)) dut (
      .clk4f (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are examined 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   logic [7:0] seq_byte [4];

   initial begin
      seq_byte[0] = 8'hA0;
      seq_byte[1] = 8'hB0;
      seq_byte[2] = 8'hC0;
      seq_byte[3] = 8'hD0;

      reset   = 1'b1;
      bus.req = 4'hF;
      bus.in0 = 8'hA0;
      bus.in1 = 8'hB0;
      bus.in2 = 8'hC0;
      bus.in3 = 8'hD0;
      step();
      step();

      // Reset state.
      check("rst_gnt",   bus.gnt,       4'b0000);
      check("rst_valid", bus.valid_out, 1'b0);
      check("rst_out",   bus.out,       8'h00);
      check("rst_lane",  bus.lane_id,   2'd0);
      check("rst_busy",  bus.busy,      1'b0);

      // First grant goes to lane 0; first byte two cycles after reset drops.
      reset = 1'b0;
      step();
      check("first_gnt",   bus.gnt,       4'b0001);
      check("first_busy",  bus.busy,      1'b1);
      check("first_noval", bus.valid_out, 1'b0);
      step();
      check("first_valid", bus.valid_out, 1'b1);
      check("first_out",   bus.out,       8'hA0);
      check("first_lane",  bus.lane_id,   2'd0);

      // All lanes requesting: 4 bytes per lane, rotating, no bubbles, wrapping back to lane 0.
      for (int k = 1; k < 20; k++) begin
         step();
         check("rr_valid", bus.valid_out, 1'b1);
         check("rr_out",   bus.out,       seq_byte[(k / 4) % 4]);
         check("rr_lane",  bus.lane_id,   32'((k / 4) % 4));
      end

      // Reset on the 3rd byte of a lane-0 burst aborts it.
      do_reset();
      step();
      check("ab_gnt0", bus.gnt, 4'b0001);
      step();
      step();
      check("ab_b2", bus.out, 8'hA0);
      reset = 1'b1;
      step();
      check("ab_gnt",   bus.gnt,       4'b0000);
      check("ab_valid", bus.valid_out, 1'b0);
      check("ab_out",   bus.out,       8'h00);
      check("ab_busy",  bus.busy,      1'b0);
      check("ab_lane",  bus.lane_id,   2'd0);

      // Single requester on lane 2 streams across burst boundaries.
      bus.req = 4'b0100;
      bus.in2 = 8'h5C;
      do_reset();
      step();
      check("sg_gnt0", bus.gnt, 4'b0100);
      for (int k = 0; k < 10; k++) begin
         step();
         check("sg_valid", bus.valid_out, 1'b1);
         check("sg_out",   bus.out,       8'h5C);
         check("sg_lane",  bus.lane_id,   2'd2);
         check("sg_gnt",   bus.gnt,       4'b0100);
      end
      bus.req = 4'b0000;
      step();
      step();
      check("sg_idle_gnt",  bus.gnt,  4'b0000);
      check("sg_idle_busy", bus.busy, 1'b0);

      // Lanes 1 and 3; lane 1 drops after two transfers -> one idle output cycle.
      bus.req = 4'b1010;
      bus.in1 = 8'h11;
      bus.in3 = 8'h33;
      do_reset();
      step();
      check("dr_gnt1", bus.gnt, 4'b0010);
      step();
      check("dr_b1", bus.out, 8'h11);
      step();
      check("dr_b2",  bus.out,       8'h11);
      check("dr_v2",  bus.valid_out, 1'b1);
      bus.req = 4'b1000;
      step();
      check("dr_bubble",  bus.valid_out, 1'b0);
      check("dr_hold",    bus.out,       8'h11);
      check("dr_holdln",  bus.lane_id,   2'd1);
      check("dr_gnt3",    bus.gnt,       4'b1000);
      step();
      check("dr_v3",    bus.valid_out, 1'b1);
      check("dr_out3",  bus.out,       8'h33);
      check("dr_lane3", bus.lane_id,   2'd3);

      // Lane 0 rises while lane 1 is bursting against lane 3.
      bus.req = 4'b1010;
      bus.in0 = 8'h00;
      do_reset();
      step();
      check("pr_gnt1", bus.gnt, 4'b0010);
      bus.req = 4'b1011;
      step();
      step();
      step();
      check("pr_hold", bus.gnt, 4'b0010);
      step();
`ifdef MUX_LANE0_PRIO_EN
      check("pr_next", bus.gnt, 4'b0001);
`else
      check("pr_next", bus.gnt, 4'b1000);
`endif
      check("pr_last", bus.out, 8'h11);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
